// File: rtl/pulpemu_rst_pkg.sv
// Shared types for the emulation reset sequencer.
package pulpemu_rst_pkg;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_STRETCH = 2'd1,
    S_RUN     = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_BTN  = 2'd1,
    CAUSE_JTAG = 2'd2,
    CAUSE_BOTH = 2'd3
  } cause_e;

  // Encode the active sources into a cause code: bit1 = JTAG, bit0 = button.
  function automatic cause_e cause_from_src(input logic trst_sync, input logic btn_deb);
    return cause_e'({~trst_sync, btn_deb});
  endfunction

endpackage

// File: rtl/pulpemu_debounce.sv
// Button synchroniser plus stable-count debouncer.
module pulpemu_debounce #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);

  logic [STAGES-1:0] sync_q;
  logic              synced;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              deb_q, deb_d;

  assign synced = sync_q[STAGES-1];
  assign q_o    = deb_q;

  // Synchroniser chain on the raw pin.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  // Count consecutive cycles the synced input disagrees with the output.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (synced != deb_q) begin
      if (cnt_q == CNT_W'(CYCLES - 1)) deb_d = synced;
      else                             cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

endmodule

// File: rtl/pulpemu_reset_ctrl.sv
// Reset sequencer: merges button and TRST into a stretched, glitch-free reset_n.
module pulpemu_reset_ctrl
  import pulpemu_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_reset_i,
  input  logic       jtag_trst_ni,
  output logic       reset_n_o,
  output logic [1:0] cause_o
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] trst_sync_q;
  logic                   trst_sync;
  logic                   btn_deb;
  logic                   src_active;

  state_e                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  cause_e                 cause_q, cause_d;
  logic                   reset_n_q, reset_n_d;

  assign trst_sync  = trst_sync_q[SYNC_STAGES-1];
  assign src_active = btn_deb | ~trst_sync;
  assign reset_n_o  = reset_n_q;
  assign cause_o    = cause_q;

  // TRST is synchronised only; resets to the asserted level.
  always_ff @(posedge clk_i) begin
    if (rst_i) trst_sync_q <= '0;
    else       trst_sync_q <= {trst_sync_q[SYNC_STAGES-2:0], jtag_trst_ni};
  end

  pulpemu_debounce #(
    .STAGES (SYNC_STAGES),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (btn_reset_i),
    .q_o   (btn_deb)
  );

  // Next-state: hold while any source is active, then stretch the release.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cause_d    = cause_q;
    unique case (state_q)
      S_HOLD: begin
        if (!src_active) begin
          state_d    = S_STRETCH;
          hold_cnt_d = '0;
        end
      end
      S_STRETCH: begin
        if (src_active) begin
          state_d = S_HOLD;
        end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      S_RUN: begin
        if (src_active) begin
          state_d = S_HOLD;
          cause_d = cause_from_src(trst_sync, btn_deb);
        end
      end
      default: state_d = S_HOLD;
    endcase
    reset_n_d = (state_d == S_RUN);
  end

  // Sequencer registers; reset_n is a flop so it can never glitch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_HOLD;
      hold_cnt_q <= '0;
      cause_q    <= CAUSE_POR;
      reset_n_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      cause_q    <= cause_d;
      reset_n_q  <= reset_n_d;
    end
  end

endmodule

// File: tb/tb_pulpemu_reset_ctrl.sv
// Scoreboard bench: stimulus queues expected output changes, a monitor checks them.
module tb_pulpemu_reset_ctrl;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       trst_n;
  logic       reset_n;
  logic [1:0] cause;

  typedef struct {
    int       cyc;
    logic [2:0] val;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc;
  int         n_checks;
  int         n_fail;
  bit         mon_en;
  logic [2:0] prev;

  pulpemu_reset_ctrl #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .btn_reset_i  (btn),
    .jtag_trst_ni (trst_n),
    .reset_n_o    (reset_n),
    .cause_o      (cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of {reset_n, cause} must match the next queued event.
  always @(negedge clk) begin
    logic [2:0] cur;
    exp_t       e;
    cur = {reset_n, cause};
    if (mon_en && (cur !== prev)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: cyc=%0d got {rn,cause}=%b, required no change from %b",
                 cyc, cur, prev);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.val !== cur) begin
          n_fail++;
          $display("FAIL event: got {rn,cause}=%b at edge %0d, required %b at edge %0d",
                   cur, cyc, e.val, e.cyc);
        end
      end
      prev = cur;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input logic rn, input logic [1:0] cs);
    exp_t e;
    e.cyc = c;
    e.val = {rn, cs};
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  initial begin
    int a, a2, b, r0;
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    prev     = 3'b000;
    rst      = 1'b1;
    btn      = 1'b0;
    trst_n   = 1'b1;

    // 1. Power-on
    tick(1);
    mon_en = 1'b1;
    check("reset_state", {reset_n, cause}, 3'b000);
    tick(4);
    rst = 1'b0;
    r0  = cyc;
    push(r0 + 11, 1'b1, 2'd0);
    tick(10);
    check("por_still_low_edge10", {reset_n, cause}, 3'b000);
    tick(1);
    check("por_released_edge11", {reset_n, cause}, 3'b100);
    tick(4);

    // 2. Short glitch on the button is rejected
    btn = 1'b1;
    tick(3);
    btn = 1'b0;
    tick(10);
    check("glitch_rejected", {reset_n, cause}, 3'b100);

    // 3. Real button press
    btn = 1'b1;
    a   = cyc + 1;
    push(a + 6, 1'b0, 2'd1);
    tick(20);
    check("btn_held_low", {reset_n, cause}, 3'b001);
    btn = 1'b0;
    b   = cyc + 1;
    push(b + 14, 1'b1, 2'd1);
    tick(20);
    check("btn_released", {reset_n, cause}, 3'b101);

    // 4. One-cycle JTAG TRST pulse
    trst_n = 1'b0;
    a      = cyc + 1;
    push(a + 2, 1'b0, 2'd2);
    push(a + 11, 1'b1, 2'd2);
    tick(1);
    trst_n = 1'b1;
    tick(15);
    check("jtag_released", {reset_n, cause}, 3'b110);

    // 5. Second TRST pulse during the stretch restarts it
    trst_n = 1'b0;
    a      = cyc + 1;
    push(a + 2, 1'b0, 2'd2);
    tick(1);
    trst_n = 1'b1;
    tick(3);
    trst_n = 1'b0;
    a2     = cyc + 1;
    push(a2 + 11, 1'b1, 2'd2);
    tick(1);
    trst_n = 1'b1;
    tick(9);
    check("restretch_still_low", {reset_n, cause}, 3'b010);
    tick(6);
    check("restretch_released", {reset_n, cause}, 3'b110);

    // 6. rst_i in S_RUN clears cause and replays POR
    rst = 1'b1;
    push(cyc + 1, 1'b0, 2'd0);
    tick(1);
    check("rst_mid_run", {reset_n, cause}, 3'b000);
    rst = 1'b0;
    r0  = cyc;
    push(r0 + 11, 1'b1, 2'd0);
    tick(10);
    check("por2_still_low", {reset_n, cause}, 3'b000);
    tick(5);
    check("por2_released", {reset_n, cause}, 3'b100);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: got %0d events still pending, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
